sha3_pad_absorb: RTL and testbench

//  Upstream feeder for the sequential Keccak-f core (576-bit rate in, 1600-bit state out, CC cycles/permutation).

---
 rtl/sha3_pkg.sv | 18 +
 rtl/sha3_pad_absorb_if.sv | 37 +++
 rtl/sha3_pad_lane.sv | 29 ++
 rtl/sha3_pad_absorb.sv | 148 ++++++++++++++
 tb/tb_sha3_pad_absorb.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared constants and state encoding for the SHA-3 pad/absorb feeder
package sha3_pkg;

    localparam int LANE_W         = 64;
    localparam int RATE_WORDS_DEF = 9;

    localparam logic [7:0] SHA3_DOMAIN   = 8'h06;
    localparam logic [7:0] SHAKE_DOMAIN  = 8'h1F;
    localparam logic [7:0] KECCAK_DOMAIN = 8'h01;
    localparam logic [7:0] PAD_END       = 8'h80;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        OUT    = 2'd1,
        PADBLK = 2'd2
    } state_e;

endpackage

// File: rtl/sha3_pad_absorb_if.sv
// rtl/sha3_pad_absorb_if.sv - word-in / block-out handshake bundle; msg_len present with SHA3_PAD_MSGLEN_EN
interface sha3_pad_absorb_if
    import sha3_pkg::*;
#(
    parameter int RATE_WORDS = RATE_WORDS_DEF
);
    logic [LANE_W-1:0]            in_data;
    logic [3:0]                   in_bytes;
    logic                         in_last;
    logic                         in_valid;
    logic                         in_ready;
    logic [LANE_W*RATE_WORDS-1:0] blk_data;
    logic                         blk_first;
    logic                         blk_last;
    logic                         blk_valid;
    logic                         blk_ready;
`ifdef SHA3_PAD_MSGLEN_EN
    logic [63:0]                  msg_len;
`endif

    modport master (
        output in_data, in_bytes, in_last, in_valid, blk_ready,
        input  in_ready, blk_data, blk_first, blk_last, blk_valid
`ifdef SHA3_PAD_MSGLEN_EN
        , input msg_len
`endif
    );

    modport slave (
        input  in_data, in_bytes, in_last, in_valid, blk_ready,
        output in_ready, blk_data, blk_first, blk_last, blk_valid
`ifdef SHA3_PAD_MSGLEN_EN
        , output msg_len
`endif
    );

endinterface

// File: rtl/sha3_pad_lane.sv
// rtl/sha3_pad_lane.sv - masks one message lane and inserts the domain byte / final 0x80
module sha3_pad_lane
    import sha3_pkg::*;
#(
    parameter logic [7:0] DOMAIN = SHA3_DOMAIN
) (
    input  logic [LANE_W-1:0] in_data,
    input  logic [3:0]        in_bytes,
    input  logic              pad_en,
    input  logic              end_en,
    output logic [LANE_W-1:0] lane_out
);

    // Keep valid bytes, place the domain byte right after them, OR the end marker into the top byte
    always_comb begin
        lane_out = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < in_bytes) begin
                lane_out[8*i +: 8] = in_data[8*i +: 8];
            end else if (pad_en && (4'(i) == in_bytes)) begin
                lane_out[8*i +: 8] = DOMAIN;
            end
        end
        if (end_en) begin
            lane_out[LANE_W-1 -: 8] = lane_out[LANE_W-1 -: 8] | PAD_END;
        end
    end

endmodule

// File: rtl/sha3_pad_absorb.sv
// rtl/sha3_pad_absorb.sv - packs 64-bit words into padded rate blocks; SHA3_PAD_MSGLEN_EN adds msg_len
module sha3_pad_absorb
    import sha3_pkg::*;
#(
    parameter int         RATE_WORDS = RATE_WORDS_DEF,
    parameter logic [7:0] DOMAIN     = SHA3_DOMAIN
) (
    input  logic              clk,
    input  logic              rst,
    sha3_pad_absorb_if.slave  bus
);

    localparam int BLK_W = LANE_W * RATE_WORDS;
    localparam int IDX_W = $clog2(RATE_WORDS + 1);

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pad_pend_q, pad_pend_d;
    logic               first_pend_q, first_pend_d;
    logic               last_q, last_d;

    logic               in_ready_o, blk_valid_o, blk_first_o, blk_last_o;
    logic               accept, handshake, at_end, full_word, overflow, pad_now;
    logic [LANE_W-1:0]  lane_out;

    assign accept    = bus.in_valid && in_ready_o;
    assign handshake = blk_valid_o && bus.blk_ready;
    assign at_end    = (idx_q == IDX_W'(RATE_WORDS - 1));
    assign full_word = (bus.in_bytes == 4'd8);
    // A full final word in the last lane leaves no room for padding: a pad-only block follows
    assign overflow  = bus.in_last && full_word && at_end;
    assign pad_now   = bus.in_last && !overflow;

    sha3_pad_lane #(.DOMAIN(DOMAIN)) u_lane (
        .in_data  (bus.in_data),
        .in_bytes (bus.in_bytes),
        .pad_en   (pad_now),
        .end_en   (pad_now && at_end),
        .lane_out (lane_out)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            buf_q        <= '0;
            idx_q        <= '0;
            pad_pend_q   <= 1'b0;
            first_pend_q <= 1'b1;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            pad_pend_q   <= pad_pend_d;
            first_pend_q <= first_pend_d;
            last_q       <= last_d;
        end
    end

    // Next-state: fill until the rate is full or the message ends, then hold the block
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (accept && (at_end || bus.in_last)) state_d = OUT;
            OUT:     if (handshake) state_d = pad_pend_q ? PADBLK : FILL;
            PADBLK:  if (handshake) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Buffer, lane index and tag flags
    always_comb begin
        buf_d        = buf_q;
        idx_d        = idx_q;
        pad_pend_d   = pad_pend_q;
        first_pend_d = first_pend_q;
        last_d       = last_q;
        unique case (state_q)
            FILL: if (accept) begin
                buf_d[LANE_W*int'(idx_q) +: LANE_W] = lane_out;
                if (pad_now) begin
                    // Full final word: domain byte starts the next (still empty) lane
                    if (full_word) begin
                        buf_d[LANE_W*(int'(idx_q) + 1) +: LANE_W] = {{(LANE_W-8){1'b0}}, DOMAIN};
                    end
                    if (!at_end) begin
                        buf_d[BLK_W-1 -: 8] = buf_d[BLK_W-1 -: 8] | PAD_END;
                    end
                    last_d = 1'b1;
                end
                if (overflow) pad_pend_d = 1'b1;
                if (!(at_end || bus.in_last)) idx_d = idx_q + IDX_W'(1);
            end
            OUT: if (handshake) begin
                buf_d        = '0;
                idx_d        = '0;
                first_pend_d = last_q;
                last_d       = 1'b0;
                if (pad_pend_q) begin
                    buf_d[7:0]          = DOMAIN;
                    buf_d[BLK_W-1 -: 8] = buf_d[BLK_W-1 -: 8] | PAD_END;
                end
            end
            PADBLK: if (handshake) begin
                buf_d        = '0;
                pad_pend_d   = 1'b0;
                first_pend_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Handshake and tag outputs decoded from the held state
    always_comb begin
        in_ready_o  = (state_q == FILL) && !rst;
        blk_valid_o = (state_q == OUT) || (state_q == PADBLK);
        blk_first_o = blk_valid_o && first_pend_q;
        blk_last_o  = ((state_q == OUT) && last_q) || (state_q == PADBLK);
    end

    assign bus.in_ready  = in_ready_o;
    assign bus.blk_valid = blk_valid_o;
    assign bus.blk_first = blk_first_o;
    assign bus.blk_last  = blk_last_o;
    assign bus.blk_data  = buf_q;

`ifdef SHA3_PAD_MSGLEN_EN
    logic [63:0] len_q, len_d;

    // Message byte count, cleared once the final block is taken
    always_comb begin
        len_d = len_q;
        if (accept) len_d = len_q + 64'(bus.in_bytes);
        if (handshake && blk_last_o) len_d = '0;
    end

    // Length register
    always_ff @(posedge clk) begin
        if (rst) len_q <= '0;
        else     len_q <= len_d;
    end

    assign bus.msg_len = len_q;
`endif

endmodule

// File: tb/tb_sha3_pad_absorb.sv
// tb/tb_sha3_pad_absorb.sv - directed bench for sha3_pad_absorb
module tb_sha3_pad_absorb;
    import sha3_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha3_pad_absorb_if #(.RATE_WORDS(9)) bus();

    sha3_pad_absorb #(.RATE_WORDS(9), .DOMAIN(8'h06)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [575:0] exp_blk;
    logic [575:0] held;

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] w(input int i);
        return 64'h0101010101010101 * 64'(i + 1);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [63:0] d, input logic [3:0] nb, input logic lst);
        int n = 0;
        assert (nb <= 4'd8 && (lst || nb == 4'd8)) else begin
            fails++;
            $error("FAIL input_legal: in_bytes %0d in_last %0d", nb, lst);
        end
        bus.in_data  = d;
        bus.in_bytes = nb;
        bus.in_last  = lst;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("in_ready_wait", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called at posedge+1; checks the presented block, then accepts it
    task automatic take(input string tag, input logic [575:0] d, input logic f, input logic l,
                        input logic [63:0] len);
        int n = 0;
        @(negedge clk);
        while (!bus.blk_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_valid"}, bus.blk_valid, 1'b1);
        chk({tag, "_data"},  bus.blk_data,  d);
        chk({tag, "_first"}, bus.blk_first, f);
        chk({tag, "_last"},  bus.blk_last,  l);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
`ifdef SHA3_PAD_MSGLEN_EN
        if (l) chk({tag, "_msg_len"}, bus.msg_len, len);
`else
        if (len == 64'hFFFF_FFFF_FFFF_FFFF) $display("len %0d", len);
`endif
        bus.blk_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.blk_ready = 1'b0;
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_bytes  = '0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.blk_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_low", bus.in_ready, 1'b0);
        chk("rst_blk_valid", bus.blk_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("post_rst_first", bus.blk_first, 1'b0);
        chk("post_rst_last", bus.blk_last, 1'b0);
        chk("post_rst_data", bus.blk_data, '0);
        @(posedge clk);
        #1;

        // Empty message
        send(64'h0, 4'd0, 1'b1);
        chk("empty_latency", bus.blk_valid, 1'b1);
        exp_blk = '0;
        exp_blk[63:0]    = 64'h06;
        exp_blk[575-:64] = 64'h8000000000000000;
        take("empty", exp_blk, 1'b1, 1'b1, 64'd0);

        // "abc" with junk above the valid bytes
        send(64'hFFFFFFFFFF636261, 4'd3, 1'b1);
        exp_blk = '0;
        exp_blk[63:0]    = 64'h0000000006636261;
        exp_blk[575-:64] = 64'h8000000000000000;
        take("abc", exp_blk, 1'b1, 1'b1, 64'd3);

        // 16 bytes: domain starts lane 2
        send(w(0), 4'd8, 1'b0);
        send(64'h0202020202020202, 4'd8, 1'b1);
        exp_blk = '0;
        exp_blk[63:0]    = 64'h0101010101010101;
        exp_blk[127:64]  = 64'h0202020202020202;
        exp_blk[191:128] = 64'h06;
        exp_blk[575-:64] = 64'h8000000000000000;
        take("b16", exp_blk, 1'b1, 1'b1, 64'd16);

        // 71 bytes: domain on the final byte -> 0x86
        exp_blk = '0;
        for (int i = 0; i < 8; i++) begin
            send(w(i), 4'd8, 1'b0);
            exp_blk[64*i +: 64] = w(i);
        end
        send(64'hAA09090909090909, 4'd7, 1'b1);
        exp_blk[575-:64] = 64'h8609090909090909;
        take("b71", exp_blk, 1'b1, 1'b1, 64'd71);

        // 72 bytes: data block then pad-only block
        exp_blk = '0;
        for (int i = 0; i < 9; i++) begin
            send(w(i), 4'd8, i == 8);
            exp_blk[64*i +: 64] = w(i);
        end
        take("b72_blk1", exp_blk, 1'b1, 1'b0, 64'd72);
        exp_blk = '0;
        exp_blk[63:0]    = 64'h06;
        exp_blk[575-:64] = 64'h8000000000000000;
        take("b72_pad", exp_blk, 1'b0, 1'b1, 64'd72);

        // Backpressure: ready low 5 cycles, accept on the 6th
        send(64'h0000000000636261, 4'd3, 1'b1);
        held = bus.blk_data;
        exp_blk = '0;
        exp_blk[63:0]    = 64'h0000000006636261;
        exp_blk[575-:64] = 64'h8000000000000000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", bus.blk_valid, 1'b1);
            chk("bp_data", bus.blk_data, exp_blk);
            chk("bp_stable", bus.blk_data, held);
            chk("bp_in_ready", bus.in_ready, 1'b0);
        end
        bus.blk_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.blk_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", bus.in_ready, 1'b1);
        chk("bp_release_valid", bus.blk_valid, 1'b0);
        @(posedge clk);
        #1;

        // Reset after 4 words: no stale lanes, first tag restored
        for (int i = 0; i < 4; i++) send(w(i + 4), 4'd8, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midmsg_rst_valid", bus.blk_valid, 1'b0);
        chk("midmsg_rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        send(64'h0000000000636261, 4'd3, 1'b1);
        take("after_rst_abc", exp_blk, 1'b1, 1'b1, 64'd3);

        // Reset while a non-first block is held
        exp_blk = '0;
        for (int i = 0; i < 9; i++) begin
            send(w(i), 4'd8, 1'b0);
            exp_blk[64*i +: 64] = w(i);
        end
        take("long_blk1", exp_blk, 1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 9; i++) send(w(i), 4'd8, 1'b0);
        @(negedge clk);
        chk("long_blk2_first", bus.blk_first, 1'b0);
        chk("long_blk2_last", bus.blk_last, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("hold_rst_cycle_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("hold_rst_valid_fell", bus.blk_valid, 1'b0);
        @(posedge clk);
        #1;
        send(64'h0000000000636261, 4'd3, 1'b1);
        exp_blk = '0;
        exp_blk[63:0]    = 64'h0000000006636261;
        exp_blk[575-:64] = 64'h8000000000000000;
        take("after_hold_rst", exp_blk, 1'b1, 1'b1, 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
